// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter
// Brief    : CPU-priority arbiter for the negedge-clocked data RAM, with a
//            bounded-latency forced display slot. Optional: RAM_ARB_STATS_EN.
// Revision : 1.0
// ============================================================================
module ram_port_arbiter #(
   parameter int ADDR_W   = 19,
   parameter int DATA_W   = 8,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic              disp_gnt,
   output logic [DATA_W-1:0] disp_rdata,
   output logic              disp_rvalid,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_wren,
   input  logic [DATA_W-1:0] ram_q
`ifdef RAM_ARB_STATS_EN
   ,
   output logic [31:0]       cnt_cpu_gnt,
   output logic [31:0]       cnt_disp_gnt,
   output logic [15:0]       cnt_stall
`endif
);

   if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
      $error("ram_port_arbiter: MAX_WAIT must be in 1..15");
   end

   localparam logic [3:0] c_WAIT_LIM = 4'(MAX_WAIT - 1);

   typedef enum logic [0:0] {
      S_CPU   = 1'b0,
      S_FORCE = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [3:0]        r_wait;
   logic [3:0]        w_wait_nxt;
   logic [ADDR_W-1:0] r_last_addr;
   logic [DATA_W-1:0] r_last_wdata;
   logic              r_rvalid;
   logic [DATA_W-1:0] r_rdata;
   logic              w_cpu_own;
   logic              w_disp_own;

   always_comb begin
      w_cpu_own   = 1'b0;
      w_disp_own  = 1'b0;
      cpu_stall   = 1'b0;
      w_state_nxt = S_CPU;
      w_wait_nxt  = r_wait;
      if (!rst) begin
         case (r_state)
            S_FORCE: begin
               w_disp_own = 1'b1;
               cpu_stall  = cpu_req;
            end
            default: begin
               w_cpu_own  = cpu_req;
               w_disp_own = !cpu_req && disp_req;
            end
         endcase
      end
      // Saturating denial counter; a granted or withdrawn request restarts it.
      if (w_disp_own || !disp_req) begin
         w_wait_nxt = 4'd0;
      end else if (r_wait != 4'hF) begin
         w_wait_nxt = r_wait + 4'd1;
      end
      if (r_state == S_CPU && disp_req && !w_disp_own && r_wait == c_WAIT_LIM) begin
         w_state_nxt = S_FORCE;
      end
   end

   assign disp_gnt    = w_disp_own;
   assign ram_wren    = w_cpu_own && cpu_we;
   assign ram_addr    = rst        ? '0 :
                        w_cpu_own  ? cpu_addr :
                        w_disp_own ? disp_addr : r_last_addr;
   assign ram_wdata   = rst        ? '0 :
                        w_cpu_own  ? cpu_wdata : r_last_wdata;
   assign cpu_rdata   = ram_q;
   assign disp_rdata  = r_rdata;
   assign disp_rvalid = r_rvalid;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_CPU;
         r_wait       <= 4'd0;
         r_last_addr  <= '0;
         r_last_wdata <= '0;
         r_rvalid     <= 1'b0;
         r_rdata      <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_wait       <= w_wait_nxt;
         r_last_addr  <= ram_addr;
         r_last_wdata <= ram_wdata;
         r_rvalid     <= w_disp_own;
         if (w_disp_own) begin
            r_rdata <= ram_q;
         end
      end
   end

`ifdef RAM_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_cpu_gnt  <= '0;
         cnt_disp_gnt <= '0;
         cnt_stall    <= '0;
      end else begin
         if (w_cpu_own && cnt_cpu_gnt != '1) begin
            cnt_cpu_gnt <= cnt_cpu_gnt + 32'd1;
         end
         if (w_disp_own && cnt_disp_gnt != '1) begin
            cnt_disp_gnt <= cnt_disp_gnt + 32'd1;
         end
         if (cpu_stall && cnt_stall != '1) begin
            cnt_stall <= cnt_stall + 16'd1;
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_port_arbiter
// Brief    : Scoreboard bench for ram_port_arbiter with a negedge RAM model.
// Revision : 1.0
// ============================================================================
module tb_ram_port_arbiter;

   localparam int ADDR_W   = 19;
   localparam int DATA_W   = 8;
   localparam int MAX_WAIT = 4;

   logic              clk;
   logic              rst;
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_stall;
   logic              disp_req;
   logic [ADDR_W-1:0] disp_addr;
   logic              disp_gnt;
   logic [DATA_W-1:0] disp_rdata;
   logic              disp_rvalid;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic              ram_wren;
   logic [DATA_W-1:0] ram_q;
`ifdef RAM_ARB_STATS_EN
   logic [31:0]       cnt_cpu_gnt;
   logic [31:0]       cnt_disp_gnt;
   logic [15:0]       cnt_stall;
`endif

   ram_port_arbiter #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .MAX_WAIT (MAX_WAIT)
   ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .cpu_req      (cpu_req),
      .cpu_we       (cpu_we),
      .cpu_addr     (cpu_addr),
      .cpu_wdata    (cpu_wdata),
      .cpu_rdata    (cpu_rdata),
      .cpu_stall    (cpu_stall),
      .disp_req     (disp_req),
      .disp_addr    (disp_addr),
      .disp_gnt     (disp_gnt),
      .disp_rdata   (disp_rdata),
      .disp_rvalid  (disp_rvalid),
      .ram_addr     (ram_addr),
      .ram_wdata    (ram_wdata),
      .ram_wren     (ram_wren),
      .ram_q        (ram_q)
`ifdef RAM_ARB_STATS_EN
      ,
      .cnt_cpu_gnt  (cnt_cpu_gnt),
      .cnt_disp_gnt (cnt_disp_gnt),
      .cnt_stall    (cnt_stall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Environment RAM: address registered on the falling edge, read-old-data.
   bit [7:0] ram_mem [0:524287];
   always @(negedge clk) begin
      ram_q <= ram_mem[ram_addr];
      if (ram_wren) ram_mem[ram_addr] <= ram_wdata;
   end

   typedef struct {
      logic              gnt;
      logic              stall;
      logic              wren;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic              chk_rd;
      logic [DATA_W-1:0] rd;
      logic              rv;
      logic [DATA_W-1:0] drd;
      int unsigned       n_cpu;
      int unsigned       n_disp;
      int unsigned       n_stall;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model: how long the display has been refused, whether its
   // slot is now owed, and the byte contents the RAM should hold.
   bit [7:0]          mdl_mem [0:524287];
   bit                m_owed;
   int                m_refused;
   logic              m_rv;
   logic [DATA_W-1:0] m_rdata;
   logic [ADDR_W-1:0] m_last_addr;
   logic [DATA_W-1:0] m_last_wdata;
   int unsigned       m_ncpu, m_ndisp, m_nstall;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cycle(input logic r, input logic creq, input logic cwe,
                        input logic [ADDR_W-1:0] caddr, input logic [DATA_W-1:0] cwd,
                        input logic dreq, input logic [ADDR_W-1:0] daddr,
                        output logic gnt);
      exp_t e;
      logic own;
      @(posedge clk);
      #1;
      rst = r; cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
      disp_req = dreq; disp_addr = daddr;
      e.rv = m_rv; e.drd = m_rdata;
      e.n_cpu = m_ncpu; e.n_disp = m_ndisp; e.n_stall = m_nstall;
      e.rd = mdl_mem[caddr];
      if (r) begin
         own = 1'b0; e.gnt = 1'b0; e.stall = 1'b0; e.wren = 1'b0;
         e.addr = '0; e.wdata = '0; e.chk_rd = 1'b0;
         m_owed = 0; m_refused = 0; m_rv = 1'b0; m_rdata = '0;
         m_last_addr = '0; m_last_wdata = '0;
         m_ncpu = 0; m_ndisp = 0; m_nstall = 0;
      end else begin
         own     = !m_owed && creq;
         e.gnt   = m_owed || (!creq && dreq);
         e.stall = m_owed && creq;
         e.wren  = own && cwe;
         e.addr  = own ? caddr : (e.gnt ? daddr : m_last_addr);
         e.wdata = own ? cwd : m_last_wdata;
         e.chk_rd = own && !cwe;
         if (e.gnt) m_rdata = mdl_mem[daddr];
         m_rv = e.gnt;
         if (e.gnt || !dreq) m_refused = 0;
         else m_refused = (m_refused < 15) ? m_refused + 1 : 15;
         m_owed = (m_refused >= MAX_WAIT);
         m_last_addr = e.addr; m_last_wdata = e.wdata;
         if (e.wren) mdl_mem[caddr] = cwd;
         if (own) m_ncpu++;
         if (e.gnt) m_ndisp++;
         if (e.stall) m_nstall++;
      end
      gnt = e.gnt;
      sb.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #8;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("disp_gnt", 32'(disp_gnt), 32'(e.gnt));
            chk("cpu_stall", 32'(cpu_stall), 32'(e.stall));
            chk("ram_wren", 32'(ram_wren), 32'(e.wren));
            chk("ram_addr", 32'(ram_addr), 32'(e.addr));
            chk("ram_wdata", 32'(ram_wdata), 32'(e.wdata));
            chk("disp_rvalid", 32'(disp_rvalid), 32'(e.rv));
            chk("disp_rdata", 32'(disp_rdata), 32'(e.drd));
            if (e.chk_rd) chk("cpu_rdata", 32'(cpu_rdata), 32'(e.rd));
`ifdef RAM_ARB_STATS_EN
            chk("cnt_cpu_gnt", cnt_cpu_gnt, 32'(e.n_cpu));
            chk("cnt_disp_gnt", cnt_disp_gnt, 32'(e.n_disp));
            chk("cnt_stall", 32'(cnt_stall), 32'(e.n_stall));
`endif
         end
      end
   end

   initial begin : driver
      logic              g;
      logic              d_req;
      logic [ADDR_W-1:0] d_addr;
      logic              creq, cwe;
      rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      disp_req = 1'b0; disp_addr = '0;
      m_owed = 0; m_refused = 0; m_rv = 1'b0; m_rdata = '0;
      m_last_addr = '0; m_last_wdata = '0; m_ncpu = 0; m_ndisp = 0; m_nstall = 0;
      ram_mem[19'h12C00] = 8'h3C;
      mdl_mem[19'h12C00] = 8'h3C;

      repeat (2) cycle(1, 0, 0, '0, '0, 0, '0, g);
      // CPU store then load
      cycle(0, 1, 1, 19'h00010, 8'hA5, 0, '0, g);
      cycle(0, 1, 0, 19'h00010, 8'h00, 0, '0, g);
      // Display alone, then an idle cycle for its rvalid
      cycle(0, 0, 0, '0, '0, 1, 19'h12C00, g);
      cycle(0, 0, 0, '0, '0, 0, '0, g);
      // Starvation from a clean reset: display held high throughout
      cycle(1, 0, 0, '0, '0, 0, '0, g);
      for (int i = 0; i < 10; i++) cycle(0, 1, 0, 19'h00005, '0, 1, 19'h12C00, g);
      // Store lands on a forced cycle, is held, then read back
      cycle(1, 0, 0, '0, '0, 0, '0, g);
      for (int i = 0; i < 4; i++) cycle(0, 1, 0, 19'h00010, '0, 1, 19'h00011, g);
      cycle(0, 1, 1, 19'h00020, 8'h77, 1, 19'h00011, g);
      cycle(0, 1, 1, 19'h00020, 8'h77, 0, '0, g);
      cycle(0, 1, 0, 19'h00020, 8'h00, 0, '0, g);
      // Reset in the cycle after a display grant
      cycle(0, 0, 0, '0, '0, 1, 19'h12C00, g);
      cycle(1, 0, 0, '0, '0, 0, '0, g);
      cycle(0, 0, 0, '0, '0, 0, '0, g);
      cycle(0, 0, 0, '0, '0, 0, '0, g);

      d_req = 1'b0; d_addr = '0;
      for (int i = 0; i < 2000; i++) begin
         if (!d_req && $urandom_range(0, 9) < 5) begin
            d_req = 1'b1;
            d_addr = 19'($urandom_range(0, 63));
         end else if (d_req && !m_owed && $urandom_range(0, 19) == 0) begin
            d_req = 1'b0;
         end
         creq = ($urandom_range(0, 9) < 7);
         cwe  = ($urandom_range(0, 9) < 4);
         cycle(($urandom_range(0, 79) == 0), creq, cwe, 19'($urandom_range(0, 63)),
               8'($urandom), d_req, d_addr, g);
         if (g) d_req = 1'b0;
      end

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      #9;
      if (sb.size() != 0) begin
         total++; bad++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port data RAM (19-bit address, 8-bit data, clocked on ~clk) between two requesters: the RSA ASIP processor and the VGA display read path.
- Sits between the cpu, the display controller and the data_memory instance at the rsa_asip_system level.
- The CPU has fixed priority. A wait counter bounds display latency by inserting a one-cycle CPU stall when the display has waited too long.
- Because the RAM is negedge-clocked, read data is available within the same clk cycle as the granted address.

Parameters:
ADDR_W, 19, RAM address width
DATA_W, 8, RAM data width
MAX_WAIT, 4, consecutive denied display cycles before a forced display slot (legal range 1..15)

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
cpu_req  in  1  CPU memory access this cycle (load or store)
cpu_we  in  1  CPU store enable, qualified by cpu_req
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU store data
cpu_rdata  out  DATA_W  RAM q, valid in the same cycle as a CPU grant
cpu_stall  out  1  CPU must hold its current memory access and PC this cycle
disp_req  in  1  display read request; held high until disp_gnt
disp_addr  in  ADDR_W  display read address; stable while disp_req is high
disp_gnt  out  1  display access owns the RAM this cycle
disp_rdata  out  DATA_W  registered read data
disp_rvalid  out  1  disp_rdata valid; high for exactly 1 cycle, one cycle after disp_gnt
ram_addr  out  ADDR_W  to RAM address
ram_wdata  out  DATA_W  to RAM data
ram_wren  out  1  to RAM write enable
ram_q  in  DATA_W  from RAM q

Behaviour:
- Grant logic is combinational from state and requests. Owner and wait state are registered.
- States: S_CPU (normal, CPU priority) and S_FORCE (display slot forced).
- S_CPU:
  - cpu_req=1: the CPU owns the RAM.
  - cpu_req=0 and disp_req=1: the display owns the RAM, disp_gnt=1.
  - Neither requesting: RAM idle, ram_wren=0, ram_addr holds the last driven address.
- S_FORCE:
  - The display owns the RAM and disp_gnt=1.
  - cpu_stall = cpu_req. A stalled CPU access is neither written nor granted.
  - S_FORCE lasts exactly 1 cycle, then returns to S_CPU.
- Wait counter (4-bit):
  - Clears on any disp_gnt or when disp_req=0.
  - Increments on each cycle with disp_req=1 and disp_gnt=0.
  - When the counter equals MAX_WAIT-1 and the display is denied this cycle, the next state is S_FORCE.
- Worst-case display grant latency: MAX_WAIT cycles after disp_req rises.
- Write path: ram_wren = cpu_req & cpu_we & CPU-owned. The display never writes.
- Read data:
  - cpu_rdata = ram_q (combinational passthrough).
  - On a disp_gnt cycle, disp_rdata <= ram_q at the rising edge, and disp_rvalid=1 in the following cycle.
  - disp_rdata holds its value otherwise.
- Simultaneous cpu_req and disp_req in S_CPU: the CPU wins and the display wait count advances.
- Back-to-back display requests with the CPU idle: disp_gnt every cycle, and disp_rvalid streams continuously.
- disp_req dropped before grant: the counter clears, and no rvalid is produced.
- Reset (synchronous, any time, including the cycle after a grant):
  - State=S_CPU, wait=0.
  - cpu_stall=0, disp_gnt=0, disp_rvalid=0, disp_rdata=0, ram_wren=0, ram_addr=0, ram_wdata=0.
  - A pending rvalid is cancelled.
- The counter saturates and never wraps. A MAX_WAIT outside 1..15 is a elaboration error.

Optional Feature:
- Macro: RAM_ARB_STATS_EN.
- When defined, the following are added:
  - Output cnt_cpu_gnt (32 bit): count of CPU-owned cycles.
  - Output cnt_disp_gnt (32 bit): count of display-owned cycles.
  - Output cnt_stall (16 bit): count of forced-stall cycles with cpu_req=1.
  - All counters clear on rst and saturate at all-ones.
- When undefined, these ports and registers do not exist, and the arbitration behaviour is identical.

Test Plan:
- CPU store then load:
  - Stimulus: cpu_req=1, cpu_we=1, addr 0x00010, data 0xA5; next cycle cpu_req=1, cpu_we=0, same address.
  - Required: ram_wren=1 only in the first cycle, and cpu_rdata=0xA5 in the second cycle.
- Display alone:
  - Stimulus: disp_req=1, addr 0x12C00 (RAM preloaded 0x3C); CPU idle.
  - Required: disp_gnt in the same cycle, disp_rvalid=1 with disp_rdata=0x3C next cycle, cpu_stall never set.
- Starvation:
  - Stimulus: cpu_req=1 continuously, disp_req=1 from cycle 0, MAX_WAIT=4.
  - Required: disp_gnt=0 in cycles 0-3, disp_gnt=1 and cpu_stall=1 in cycle 4, disp_rvalid in cycle 5, CPU regains the RAM in cycle 5.
- Conflict on write:
  - Stimulus: a CPU store in a forced cycle.
  - Required: ram_wren=0 in that cycle; the store completes the next cycle when held, and the RAM holds the new value afterwards.
- Reset mid-read:
  - Stimulus: rst=1 in the cycle after disp_gnt.
  - Required: disp_rvalid=0, disp_rdata=0, wait counter=0, state S_CPU the next cycle.
- Stats (RAM_ARB_STATS_EN):
  - Stimulus: run the starvation scenario for 10 cycles.
  - Required: cnt_stall=2, cnt_disp_gnt=2, cnt_cpu_gnt=8.
